alu_iterative: RTL and testbench
================================

Name: alu_iterative

Overview:
- Datapath ALU and the consumer of the 4-bit alu_control code produced by the ALU control decoder.
- Executes all single-cycle R/I-type operations with a one-edge registered latency.
- Executes signed MULT iteratively (radix-2 shift-add, 32 iterations) into dedicated HI/LO registers, using a valid/ready handshake toward the pipeline stall logic.

Parameters:
- WIDTH, 32, operand and result width; the multiplier counter is sized by $clog2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  operation request; sampled only while ready=1.
- alu_ctrl  in  4  operation code: AND=0, OR=1, ADD=2, SLL=3, SRL=4, SUB=5, SLT=7, MULT=8, NOR=12.
- alu_in_0  in  WIDTH  operand A (rs).
- alu_in_1  in  WIDTH  operand B (rt; the source for shifts).
- shamt  in  5  shift amount for SLL/SRL.
- ready  out  1  block can accept a request this cycle.
- valid_out  out  1  one-cycle pulse; alu_out/hi/lo are valid.
- alu_out  out  WIDTH  registered result.
- zero  out  1  registered (alu_out==0).
- overflow  out  1  registered signed overflow (ADD/SUB only).
- hi_out  out  WIDTH  HI register (upper product half).
- lo_out  out  WIDTH  LO register (lower product half).

Behaviour:
- Reset (async, arst_n=0): state IDLE, ready=1, valid_out=0, alu_out=0, zero=0, overflow=0, hi_out=0, lo_out=0, counter=0. A reset during MUL aborts the operation; no partial result is visible.
- States: IDLE, MUL.
- IDLE, valid_in=1, alu_ctrl!=MULT at edge E0:
  - alu_out, zero and overflow are updated at E0.
  - valid_out=1 for exactly the cycle after E0.
  - State stays IDLE; ready stays 1, so back-to-back ops are accepted every cycle.
- Single-cycle op semantics:
  - ADD/SUB are WIDTH-bit wrap-around. overflow=1 when the operand signs match (ADD) or differ (SUB) and the result sign differs from alu_in_0.
  - SLT is signed compare; the result is 1 or 0.
  - SLL = alu_in_1<<shamt; SRL = logical alu_in_1>>shamt; NOR = ~(A|B).
  - Undefined alu_ctrl codes give alu_out=0 and overflow=0, with valid_out still pulsed.
- IDLE, valid_in=1, alu_ctrl=MULT at edge E0:
  - Latch sign = A[msb]^B[msb], mcand=|A|, lo_work=|B|, hi_work=0, counter=0.
  - Go to MUL; ready=0 from E0.
  - |0x80000000| = 0x80000000 as unsigned, with no overflow.
- MUL, each edge:
  - If lo_work[0], hi_work += mcand as a (WIDTH+1)-bit sum.
  - Then shift {carry,hi_work,lo_work} right by 1.
  - counter increments.
- Completion at edge E32, the 32nd MUL edge:
  - The final product is negated (2's complement, 64-bit) when sign=1.
  - Write hi_out/lo_out; alu_out=lo value; zero=(lo==0); overflow=0.
  - valid_out=1 for one cycle; state returns to IDLE; ready=1.
  - Total: request accepted at E0, result visible after E32.
- valid_in while ready=0 is ignored with no side effects; the requester must hold it until ready=1.
- A new request is accepted in the same cycle valid_out pulses for a MULT result.
- hi_out/lo_out change only on MULT completion or reset. Single-cycle ops never modify them.
- Operand inputs need only be stable at E0; the block holds internal copies during MUL.

Test Plan:
- Reset -> ready=1, valid_out=0, alu_out/hi/lo=0. Release, then ADD 0x00000005+0x00000003 -> alu_out=0x8, zero=0, valid_out pulse one cycle later.
- ADD 0x7FFFFFFF+1 -> alu_out=0x80000000, overflow=1. SUB 5-5 -> alu_out=0, zero=1, overflow=0. SLT 0xFFFFFFFF,1 -> 1. SRL 0x80000000 by shamt=31 -> 0x1.
- MULT -7 (0xFFFFFFF9) × 3 -> ready=0 for 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, alu_out=0xFFFFFFEB, valid_out pulse exactly 32 edges after accept.
- MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000, zero=1. MULT 0xFFFFFFFF × 0xFFFFFFFF -> hi=0, lo=1.
- Issue ADD at every edge while a MULT is busy -> no valid_out until MULT completes; hi/lo are unchanged by the ignored ADDs. An ADD presented in the completion cycle is accepted -> its valid_out comes one cycle later.
- Assert arst_n=0 at MUL iteration 15 -> outputs 0 immediately, ready=1. After release a new MULT 2×3 -> hi=0, lo=6.

Source files
------------

// File: rtl/alu_iterative.sv
// Datapath ALU: single-cycle R/I-type ops with one-edge registered latency,
// plus signed MULT via a 32-step radix-2 shift-add into HI/LO.
module alu_iterative #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             valid_in,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_in_0,
  input  logic [WIDTH-1:0] alu_in_1,
  input  logic [4:0]       shamt,
  output logic             ready,
  output logic             valid_out,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned PROD_W = 2 * WIDTH;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8;
  localparam logic [3:0] OP_NOR  = 4'd12;

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_work_q, hi_work_d;
  logic [WIDTH-1:0]   lo_work_q, lo_work_d;

  logic               ready_d, valid_d, zero_d, ovf_d;
  logic [WIDTH-1:0]   alu_d, hi_d, lo_d;

  logic [WIDTH-1:0]   add_sum, sub_diff, abs_a, abs_b;
  logic [WIDTH-1:0]   op_res;
  logic               op_ovf;
  logic [WIDTH:0]     partial;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [PROD_W-1:0]  prod_abs, prod_fin;

  assign add_sum  = alu_in_0 + alu_in_1;
  assign sub_diff = alu_in_0 - alu_in_1;
  assign abs_a    = alu_in_0[WIDTH-1] ? (~alu_in_0 + WIDTH'(1)) : alu_in_0;
  assign abs_b    = alu_in_1[WIDTH-1] ? (~alu_in_1 + WIDTH'(1)) : alu_in_1;

  // One shift-add step: conditional add with carry, then shift {carry,hi,lo} right
  assign partial  = lo_work_q[0] ? ({1'b0, hi_work_q} + {1'b0, mcand_q})
                                 : {1'b0, hi_work_q};
  assign step_hi  = partial[WIDTH:1];
  assign step_lo  = {partial[0], lo_work_q[WIDTH-1:1]};
  assign prod_abs = {step_hi, step_lo};
  assign prod_fin = sign_q ? (~prod_abs + PROD_W'(1)) : prod_abs;

  // Single-cycle operation result and signed overflow
  always_comb begin
    op_res = '0;
    op_ovf = 1'b0;
    case (alu_ctrl)
      OP_AND: op_res = alu_in_0 & alu_in_1;
      OP_OR:  op_res = alu_in_0 | alu_in_1;
      OP_ADD: begin
        op_res = add_sum;
        op_ovf = (alu_in_0[WIDTH-1] == alu_in_1[WIDTH-1]) &&
                 (add_sum[WIDTH-1] != alu_in_0[WIDTH-1]);
      end
      OP_SLL: op_res = alu_in_1 << shamt;
      OP_SRL: op_res = alu_in_1 >> shamt;
      OP_SUB: begin
        op_res = sub_diff;
        op_ovf = (alu_in_0[WIDTH-1] != alu_in_1[WIDTH-1]) &&
                 (sub_diff[WIDTH-1] != alu_in_0[WIDTH-1]);
      end
      OP_SLT: op_res = WIDTH'($signed(alu_in_0) < $signed(alu_in_1));
      OP_NOR: op_res = ~(alu_in_0 | alu_in_1);
      default: begin
        op_res = '0;
        op_ovf = 1'b0;
      end
    endcase
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    mcand_d   = mcand_q;
    hi_work_d = hi_work_q;
    lo_work_d = lo_work_q;
    ready_d   = ready;
    valid_d   = 1'b0;
    alu_d     = alu_out;
    zero_d    = zero;
    ovf_d     = overflow;
    hi_d      = hi_out;
    lo_d      = lo_out;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (alu_ctrl == OP_MULT) begin
            sign_d    = alu_in_0[WIDTH-1] ^ alu_in_1[WIDTH-1];
            mcand_d   = abs_a;
            lo_work_d = abs_b;
            hi_work_d = '0;
            cnt_d     = '0;
            ready_d   = 1'b0;
            state_d   = MUL;
          end else begin
            alu_d   = op_res;
            zero_d  = (op_res == '0);
            ovf_d   = op_ovf;
            valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        hi_work_d = step_hi;
        lo_work_d = step_lo;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          hi_d    = prod_fin[PROD_W-1:WIDTH];
          lo_d    = prod_fin[WIDTH-1:0];
          alu_d   = prod_fin[WIDTH-1:0];
          zero_d  = (prod_fin[WIDTH-1:0] == '0);
          ovf_d   = 1'b0;
          valid_d = 1'b1;
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      mcand_q   <= '0;
      hi_work_q <= '0;
      lo_work_q <= '0;
      ready     <= 1'b1;
      valid_out <= 1'b0;
      alu_out   <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      mcand_q   <= mcand_d;
      hi_work_q <= hi_work_d;
      lo_work_q <= lo_work_d;
      ready     <= ready_d;
      valid_out <= valid_d;
      alu_out   <= alu_d;
      zero      <= zero_d;
      overflow  <= ovf_d;
      hi_out    <= hi_d;
      lo_out    <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative: expected results are queued at issue and
// checked (value and arrival edge) whenever valid_out pulses.
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        valid_in;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_in_0, alu_in_1;
  logic [4:0]  shamt;
  logic        ready, valid_out, zero, overflow;
  logic [31:0] alu_out, hi_out, lo_out;

  alu_iterative #(.WIDTH(32)) dut (
    .clk(clk), .arst_n(arst_n), .valid_in(valid_in), .alu_ctrl(alu_ctrl),
    .alu_in_0(alu_in_0), .alu_in_1(alu_in_1), .shamt(shamt),
    .ready(ready), .valid_out(valid_out), .alu_out(alu_out), .zero(zero),
    .overflow(overflow), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          edge_n;
    logic [31:0] alu;
    logic        zero;
    logic        ovf;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          busy_end = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then inspect outputs on the falling edge
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'(valid_out), 64'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_edge"}, 64'(cyc), 64'(e.edge_n));
        chk({e.tag, "_alu"},  64'(alu_out), 64'(e.alu));
        chk({e.tag, "_zero"}, 64'(zero), 64'(e.zero));
        chk({e.tag, "_ovf"},  64'(overflow), 64'(e.ovf));
        chk({e.tag, "_hi"},   64'(hi_out), 64'(e.hi));
        chk({e.tag, "_lo"},   64'(lo_out), 64'(e.lo));
      end
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] r, output logic ovf);
    longint      s;
    logic [63:0] su;
    ovf = 1'b0;
    r   = '0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2, 4'd5: begin
        s   = (op == 4'd2) ? longint'($signed(a)) + longint'($signed(b))
                           : longint'($signed(a)) - longint'($signed(b));
        su  = s;
        r   = su[31:0];
        ovf = (s != longint'($signed(r)));
      end
      4'd3:  r = b << sh;
      4'd4:  r = b >> sh;
      4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: r = ~(a | b);
      default: r = '0;
    endcase
  endtask

  task automatic send(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh);
    exp_t        e;
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    valid_in = 1'b1;
    alu_ctrl = op;
    alu_in_0 = a;
    alu_in_1 = b;
    shamt    = sh;
    chk({tag, "_ready"}, 64'(ready), 64'(cyc >= busy_end));
    if (cyc >= busy_end) begin
      e.tag = tag;
      if (op == 4'd8) begin
        p        = 64'(longint'($signed(a)) * longint'($signed(b)));
        hi_m     = p[63:32];
        lo_m     = p[31:0];
        busy_end = cyc + 33;
        e.edge_n = cyc + 33;
        e.alu    = lo_m;
        e.zero   = (lo_m == 32'd0);
        e.ovf    = 1'b0;
      end else begin
        model(op, a, b, sh, r, ovf);
        e.edge_n = cyc + 1;
        e.alu    = r;
        e.zero   = (r == 32'd0);
        e.ovf    = ovf;
      end
      e.hi = hi_m;
      e.lo = lo_m;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b0;
      chk("idle_ready", 64'(ready), 64'(cyc >= busy_end));
      tick();
    end
  endtask

  initial begin
    arst_n = 1'b0; valid_in = 1'b0; alu_ctrl = '0;
    alu_in_0 = '0; alu_in_1 = '0; shamt = '0;
    tick();
    tick();
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_alu",   64'(alu_out), 64'd0);
    chk("rst_zero",  64'(zero), 64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    chk("rst_hi",    64'(hi_out), 64'd0);
    chk("rst_lo",    64'(lo_out), 64'd0);
    arst_n = 1'b1;
    busy_end = cyc;

    // Back-to-back single-cycle ops
    send("add_5_3",   4'd2,  32'h0000_0005, 32'h0000_0003, 5'd0);
    send("add_ovf",   4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    send("sub_zero",  4'd5,  32'h0000_0005, 32'h0000_0005, 5'd0);
    send("sub_ovf",   4'd5,  32'h8000_0000, 32'h0000_0001, 5'd0);
    send("slt_neg",   4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    send("slt_pos",   4'd7,  32'h0000_0001, 32'hFFFF_FFFF, 5'd0);
    send("srl_31",    4'd4,  32'h0000_0000, 32'h8000_0000, 5'd31);
    send("sll_4",     4'd3,  32'h0000_0000, 32'h0F0F_0001, 5'd4);
    send("and",       4'd0,  32'hF0F0_FF00, 32'h3C3C_0FF0, 5'd0);
    send("or",        4'd1,  32'hF0F0_0000, 32'h0000_0F0F, 5'd0);
    send("nor",       4'd12, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0);
    send("undef_6",   4'd6,  32'h1234_5678, 32'h1111_1111, 5'd3);
    idle(2);

    // Iterative multiplies
    send("mult_m7_3", 4'd8,  32'hFFFF_FFF9, 32'h0000_0003, 5'd0);
    idle(33);
    send("mult_min",  4'd8,  32'h8000_0000, 32'h8000_0000, 5'd0);
    idle(33);
    send("mult_m1",   4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    idle(33);

    // ADDs presented every cycle while busy; the one in the completion cycle is taken
    send("mult_big",  4'd8,  32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
    for (int i = 0; i < 33; i++) send("add_busy", 4'd2, 32'h0000_1000, 32'(i), 5'd0);
    idle(3);

    // Reset in the middle of a multiply
    send("mult_abort", 4'd8, 32'h0000_0064, 32'h0000_00C8, 5'd0);
    idle(15);
    arst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_valid", 64'(valid_out), 64'd0);
    chk("abort_alu",   64'(alu_out), 64'd0);
    chk("abort_zero",  64'(zero), 64'd0);
    chk("abort_hi",    64'(hi_out), 64'd0);
    chk("abort_lo",    64'(lo_out), 64'd0);
    sb.delete();
    hi_m = '0;
    lo_m = '0;
    tick();
    arst_n = 1'b1;
    busy_end = cyc;
    send("mult_2_3",  4'd8,  32'h0000_0002, 32'h0000_0003, 5'd0);
    idle(36);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
